smi_frame_steer_n: RTL and testbench

- Parametrised successor to the three-way SMI frame steering block.
- Steers each SMI frame from one input to NumOutputs outputs, by masked matching of the 32-bit message type word in the frame's first flit.
- Two modes: priority (lowest matching index wins) and multicast (frame replicated to every matching output).
- Unmatched frames go to an optional default output or are discarded; discarded frames are counted.

---
 rtl/smi_frame_steer_n_pkg.sv | 27 ++
 rtl/smi_frame_steer_n_buf.sv | 55 +++++
 rtl/smi_frame_steer_n.sv | 151 +++++++++++++++
 tb/tb_smi_frame_steer_n.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_frame_steer_n_pkg.sv
// Shared definitions for the SMI frame steering block.
// Holds the SMI control/type field widths, the end-of-frame control mask
// derivation and a helper that pulls one 32-bit word out of a packed
// per-output parameter vector.
package smi_frame_steer_n_pkg;

    localparam int SMI_EOFC_W  = 8;
    localparam int TYPE_W      = 32;
    localparam int MAX_OUTPUTS = 8;

    typedef logic [MAX_OUTPUTS*TYPE_W-1:0] param_vec_t;

    // Valid eofc codes for a flit of flit_width bytes fit in 2*flit_width-1.
    function automatic logic [SMI_EOFC_W-1:0] eofc_mask(input int flit_width);
        int raw;
        raw = 2 * flit_width - 1;
        if (raw > 255) begin
            return 8'hFF;
        end
        return SMI_EOFC_W'(raw);
    endfunction

    function automatic logic [TYPE_W-1:0] param_word(input param_vec_t vec, input int idx);
        return vec[idx*TYPE_W +: TYPE_W];
    endfunction

endpackage

// File: rtl/smi_frame_steer_n_buf.sv
// Two-slot self-link buffer placed in front of each steered output.
// Slot A captures the incoming word, slot B drives the output. Words move
// A -> B whenever B is empty or being consumed, so an unstalled stream
// passes at one word per cycle with two cycles of latency.
// Ports:
//   clk, srst_n        clock, synchronous active-low reset (flushes both slots)
//   i_ready, i_data    upstream word valid / payload
//   o_stop             upstream backpressure, high only with both slots full
//   o_ready, o_data    downstream word valid / payload
//   i_stop             downstream backpressure
module smi_self_link_double_buffer #(
    parameter int Width = 136
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             i_ready,
    input  logic [Width-1:0] i_data,
    output logic             o_stop,
    output logic             o_ready,
    output logic [Width-1:0] o_data,
    input  logic             i_stop
);

    logic             r_a_valid;
    logic [Width-1:0] r_a_data;
    logic             r_b_valid;
    logic [Width-1:0] r_b_data;
    logic             w_b_free;
    logic             w_a_free;

    assign w_b_free = ~r_b_valid | ~i_stop;
    assign w_a_free = ~r_a_valid | w_b_free;
    assign o_stop   = ~w_a_free;
    assign o_ready  = r_b_valid;
    assign o_data   = r_b_data;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
        end else begin
            if (w_b_free) begin
                r_b_valid <= r_a_valid;
                r_b_data  <= r_a_data;
            end
            if (w_a_free) begin
                r_a_valid <= i_ready;
                r_a_data  <= i_data;
            end
        end
    end

endmodule

// File: rtl/smi_frame_steer_n.sv
// SMI frame steering: routes each frame from one input to NumOutputs
// outputs by masked match on the 32-bit type word of the header flit.
// Priority mode sends a frame to the lowest matching output, multicast
// mode to every matching output. Unmatched frames go to DefaultOutput or
// are discarded and counted.
// Ports:
//   clk, srst_n                         clock, synchronous active-low reset
//   smiInReady/smiInEofc/smiInData      input flit
//   smiInStop                           input backpressure
//   smiOutReady/smiOutEofc/smiOutData   per-output flit, slice i = output i
//   smiOutStop                          per-output backpressure
//   dropCount                           saturating count of discarded frames
module smi_frame_steer_n
    import smi_frame_steer_n_pkg::*;
#(
    parameter int                            FlitWidth     = 16,
    parameter int                            NumOutputs    = 4,
    parameter logic [NumOutputs*TYPE_W-1:0]  TypeMatch     = '0,
    parameter logic [NumOutputs*TYPE_W-1:0]  TypeMask      = '1,
    parameter bit                            Multicast     = 1'b0,
    parameter int                            DefaultOutput = -1
) (
    input  logic                                clk,
    input  logic                                srst_n,
    input  logic                                smiInReady,
    input  logic [SMI_EOFC_W-1:0]               smiInEofc,
    input  logic [FlitWidth*8-1:0]              smiInData,
    output logic                                smiInStop,
    output logic [NumOutputs-1:0]               smiOutReady,
    output logic [NumOutputs*SMI_EOFC_W-1:0]    smiOutEofc,
    output logic [NumOutputs*FlitWidth*8-1:0]   smiOutData,
    input  logic [NumOutputs-1:0]               smiOutStop,
    output logic [15:0]                         dropCount
);

    localparam int                    DW       = FlitWidth * 8;
    localparam logic [SMI_EOFC_W-1:0] EofcMask = eofc_mask(FlitWidth);
    localparam param_vec_t            MatchVec = param_vec_t'(TypeMatch);
    localparam param_vec_t            MaskVec  = param_vec_t'(TypeMask);
    localparam bit                    HasDefault = (DefaultOutput >= 0) && (DefaultOutput < NumOutputs);
    localparam logic [NumOutputs-1:0] DefaultSel =
        HasDefault ? (NumOutputs'(1) << (HasDefault ? DefaultOutput : 0)) : '0;

    logic                    r_in_valid;
    logic [SMI_EOFC_W-1:0]   r_in_eofc;
    logic [DW-1:0]           r_in_data;
    logic                    r_next_hdr;
    logic [NumOutputs-1:0]   r_sel;
    logic [NumOutputs-1:0]   r_acc;
    logic [15:0]             r_drop_cnt;

    logic [NumOutputs-1:0]   w_match;
    logic [NumOutputs-1:0]   w_prio;
    logic [NumOutputs-1:0]   w_sel_next;
    logic [NumOutputs-1:0]   w_buf_ready;
    logic [NumOutputs-1:0]   w_buf_stop;
    logic [NumOutputs-1:0]   w_take;
    logic                    w_complete;
    logic                    w_load;
    logic [SMI_EOFC_W-1:0]   w_eofc_in;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < NumOutputs; i++) begin
            w_match[i] = ((param_word(MaskVec, i) &
                          (param_word(MatchVec, i) ^ smiInData[TYPE_W-1:0])) == '0);
        end
    end

    // Scan from the top so the lowest matching index is the last one kept.
    always_comb begin
        w_prio = '0;
        for (int i = NumOutputs - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_prio    = '0;
                w_prio[i] = 1'b1;
            end
        end
        if (w_match == '0) begin
            w_sel_next = DefaultSel;
        end else if (Multicast) begin
            w_sel_next = w_match;
        end else begin
            w_sel_next = w_prio;
        end
    end

    // Outputs that already took the current flit are masked off so a
    // partially stalled multicast never delivers a duplicate.
    assign w_buf_ready = {NumOutputs{r_in_valid}} & r_sel & ~r_acc;
    assign w_take      = w_buf_ready & ~w_buf_stop;
    assign w_complete  = r_in_valid & (((r_acc | w_take) & r_sel) == r_sel);
    assign smiInStop   = r_in_valid & ~w_complete;
    assign w_load      = smiInReady & ~smiInStop;
    assign w_eofc_in   = smiInEofc & EofcMask;
    assign dropCount   = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_in_valid <= 1'b0;
            r_in_eofc  <= '0;
            r_in_data  <= '0;
            r_next_hdr <= 1'b1;
            r_sel      <= '0;
            r_acc      <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_complete) begin
                r_acc <= '0;
            end else begin
                r_acc <= r_acc | w_take;
            end

            if (w_load) begin
                r_in_valid <= 1'b1;
                r_in_eofc  <= w_eofc_in;
                r_in_data  <= smiInData;
                r_next_hdr <= (w_eofc_in != '0);
                if (r_next_hdr) begin
                    r_sel <= w_sel_next;
                    if ((w_sel_next == '0) && (r_drop_cnt != 16'hFFFF)) begin
                        r_drop_cnt <= r_drop_cnt + 16'd1;
                    end
                end
            end else if (w_complete) begin
                r_in_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NumOutputs; i++) begin : g_out
        logic [DW+SMI_EOFC_W-1:0] w_out_word;

        smi_self_link_double_buffer #(
            .Width (DW + SMI_EOFC_W)
        ) u_buf (
            .clk     (clk),
            .srst_n  (srst_n),
            .i_ready (w_buf_ready[i]),
            .i_data  ({r_in_eofc, r_in_data}),
            .o_stop  (w_buf_stop[i]),
            .o_ready (smiOutReady[i]),
            .o_data  (w_out_word),
            .i_stop  (smiOutStop[i])
        );

        assign smiOutEofc[i*SMI_EOFC_W +: SMI_EOFC_W] = w_out_word[DW +: SMI_EOFC_W];
        assign smiOutData[i*DW +: DW]                  = w_out_word[DW-1:0];
    end

endmodule

// File: tb/tb_smi_frame_steer_n.sv
// Bench for smi_frame_steer_n: three instances (priority, multicast,
// priority with default output 3) driven in turn, with a frame-level
// reference model feeding per-output expected queues.
module tb_smi_frame_steer_n;

    logic         clk = 1'b0;
    logic         srst_n = 1'b0;
    logic         in_ready [3];
    logic [7:0]   in_eofc  [3];
    logic [127:0] in_data  [3];
    logic         in_stop  [3];
    logic [3:0]   out_ready[3];
    logic [31:0]  out_eofc [3];
    logic [511:0] out_data [3];
    logic [3:0]   out_stop [3];
    logic [15:0]  drop_cnt [3];

    int checks = 0;
    int failures = 0;

    logic [31:0]  cfg_match[3][4];
    logic [31:0]  cfg_mask [3][4];
    bit           cfg_mc   [3];
    int           cfg_def  [3];

    logic [135:0] exp_q[12][$];
    bit           m_hdr [3];
    logic [3:0]   m_sel [3];
    int           m_drop[3];
    int           rx_cnt[3][4];
    logic [135:0] got;
    logic [135:0] want;

    always #5 clk = ~clk;

    smi_frame_steer_n #(
        .TypeMatch({32'd3, 32'd2, 32'd1, 32'd0}),
        .TypeMask({4{32'd3}}), .Multicast(1'b0), .DefaultOutput(-1)
    ) u_pri (
        .clk(clk), .srst_n(srst_n), .smiInReady(in_ready[0]), .smiInEofc(in_eofc[0]),
        .smiInData(in_data[0]), .smiInStop(in_stop[0]), .smiOutReady(out_ready[0]),
        .smiOutEofc(out_eofc[0]), .smiOutData(out_data[0]), .smiOutStop(out_stop[0]),
        .dropCount(drop_cnt[0])
    );

    smi_frame_steer_n #(
        .TypeMatch({32'h30, 32'h10, 32'h10, 32'h20}),
        .TypeMask({4{32'hFF}}), .Multicast(1'b1), .DefaultOutput(-1)
    ) u_mc (
        .clk(clk), .srst_n(srst_n), .smiInReady(in_ready[1]), .smiInEofc(in_eofc[1]),
        .smiInData(in_data[1]), .smiInStop(in_stop[1]), .smiOutReady(out_ready[1]),
        .smiOutEofc(out_eofc[1]), .smiOutData(out_data[1]), .smiOutStop(out_stop[1]),
        .dropCount(drop_cnt[1])
    );

    smi_frame_steer_n #(
        .TypeMatch({32'h30, 32'h10, 32'h10, 32'h20}),
        .TypeMask({4{32'hFF}}), .Multicast(1'b0), .DefaultOutput(3)
    ) u_def (
        .clk(clk), .srst_n(srst_n), .smiInReady(in_ready[2]), .smiInEofc(in_eofc[2]),
        .smiInData(in_data[2]), .smiInStop(in_stop[2]), .smiOutReady(out_ready[2]),
        .smiOutEofc(out_eofc[2]), .smiOutData(out_data[2]), .smiOutStop(out_stop[2]),
        .dropCount(drop_cnt[2])
    );

    // Reference: which outputs a header type is steered to.
    function automatic logic [3:0] model_sel(int k, logic [31:0] t);
        logic [3:0] m;
        m = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if ((t & cfg_mask[k][i]) == (cfg_match[k][i] & cfg_mask[k][i])) m[i] = 1'b1;
        end
        if (m == 4'b0) return (cfg_def[k] < 0) ? 4'b0 : 4'(1 << cfg_def[k]);
        if (cfg_mc[k]) return m;
        return m & (~m + 4'd1);
    endfunction

    function automatic void model_accept(int k, logic [7:0] eofc, logic [127:0] data);
        logic [7:0] e;
        e = eofc & 8'h1F;
        if (m_hdr[k]) begin
            m_sel[k] = model_sel(k, data[31:0]);
            if (m_sel[k] == 4'b0 && m_drop[k] < 65535) m_drop[k]++;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_sel[k][i]) exp_q[k*4+i].push_back({e, data});
        end
        m_hdr[k] = (e != 8'h0);
    endfunction

    function automatic void model_reset();
        for (int q = 0; q < 12; q++) exp_q[q].delete();
        for (int k = 0; k < 3; k++) begin
            m_hdr[k]  = 1'b1;
            m_sel[k]  = 4'b0;
            m_drop[k] = 0;
        end
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int q = 0; q < 12; q++) n += exp_q[q].size();
        return n;
    endfunction

    function automatic logic [31:0] pick_type();
        case ($urandom_range(0, 8))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h2;
            3: return 32'h3;
            4: return 32'h10;
            5: return 32'h20;
            6: return 32'h30;
            7: return 32'hFF;
            default: return $urandom;
        endcase
    endfunction

    // Output scoreboard: a word transfers at the next edge when ready & ~stop.
    always @(negedge clk) begin
        if (srst_n) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 4; i++) begin
                    if (out_ready[k][i] && !out_stop[k][i]) begin
                        got = {out_eofc[k][i*8 +: 8], out_data[k][i*128 +: 128]};
                        checks++;
                        if (exp_q[k*4+i].size() == 0) begin
                            failures++;
                            $display("FAIL out_unexpected inst=%0d out=%0d got=%h required=nothing", k, i, got);
                        end else begin
                            want = exp_q[k*4+i].pop_front();
                            if (got !== want) begin
                                failures++;
                                $display("FAIL out_word inst=%0d out=%0d got=%h required=%h", k, i, got, want);
                            end
                        end
                        rx_cnt[k][i]++;
                    end
                end
            end
        end
    end

    task automatic send_flit(int k, logic [7:0] eofc, logic [127:0] data, output int waits);
        waits = 0;
        in_eofc[k]  = eofc;
        in_data[k]  = data;
        in_ready[k] = 1'b1;
        @(negedge clk);
        while (in_stop[k] && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (in_stop[k]) begin
            checks++;
            failures++;
            $display("FAIL send_timeout inst=%0d waited=%0d required=<300", k, waits);
            @(posedge clk);
        end else begin
            @(posedge clk);
            model_accept(k, eofc, data);
        end
        #1;
        in_ready[k] = 1'b0;
    endtask

    task automatic send_frame(int k, logic [31:0] t, int len, output int waits_total);
        int w;
        logic [7:0]   e;
        logic [127:0] d;
        waits_total = 0;
        for (int j = 0; j < len; j++) begin
            d = {$urandom, $urandom, $urandom, (j == 0) ? t : $urandom};
            if (j == len - 1) e = {3'($urandom_range(0, 7)), 5'($urandom_range(1, 31))};
            else              e = {3'($urandom_range(0, 7)), 5'b0};
            send_flit(k, e, d, w);
            waits_total += w;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        for (int k = 0; k < 3; k++) out_stop[k] = 4'b0;
        while (pending() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_ready[k] = 1'b0;
            in_eofc[k]  = 8'h0;
            in_data[k]  = '0;
            out_stop[k] = 4'b0;
            for (int i = 0; i < 4; i++) rx_cnt[k][i] = 0;
        end
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (out_ready[k] !== 4'b0) begin
                failures++;
                $display("FAIL reset_out_ready inst=%0d got=%b required=0000", k, out_ready[k]);
            end
            if (in_stop[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_in_stop inst=%0d got=%b required=0", k, in_stop[k]);
            end
            if (drop_cnt[k] !== 16'h0) begin
                failures++;
                $display("FAIL reset_drop inst=%0d got=%0d required=0", k, drop_cnt[k]);
            end
        end
        @(posedge clk);
        #1;
        srst_n = 1'b1;
    endtask

    task automatic test_priority();
        logic [7:0]   eo[3];
        logic [127:0] d;
        int           base[4];
        eo = '{8'h00, 8'h00, 8'h05};
        for (int i = 0; i < 4; i++) base[i] = rx_cnt[0][i];
        for (int j = 0; j < 3; j++) begin
            d = {$urandom, $urandom, $urandom, (j == 0) ? 32'h2 : $urandom};
            in_eofc[0]  = eo[j];
            in_data[0]  = d;
            in_ready[0] = 1'b1;
            @(negedge clk);
            checks++;
            if (in_stop[0] !== 1'b0) begin
                failures++;
                $display("FAIL prio_in_stop flit=%0d got=1 required=0", j);
            end
            @(posedge clk);
            model_accept(0, eo[j], d);
            #1;
            if (j == 1) begin
                checks++;
                if (out_ready[0] !== 4'b0000) begin
                    failures++;
                    $display("FAIL prio_latency_early got=%b required=0000", out_ready[0]);
                end
            end
            if (j == 2) begin
                checks++;
                if (out_ready[0] !== 4'b0100) begin
                    failures++;
                    $display("FAIL prio_latency got=%b required=0100", out_ready[0]);
                end
            end
        end
        in_ready[0] = 1'b0;
        drain();
        checks += 3;
        if (rx_cnt[0][2] - base[2] !== 3) begin
            failures++;
            $display("FAIL prio_count_out2 got=%0d required=3", rx_cnt[0][2] - base[2]);
        end
        if (rx_cnt[0][0] + rx_cnt[0][1] + rx_cnt[0][3] - base[0] - base[1] - base[3] !== 0) begin
            failures++;
            $display("FAIL prio_other_outputs got=nonzero required=0");
        end
        if (drop_cnt[0] !== 16'd0) begin
            failures++;
            $display("FAIL prio_drop got=%0d required=0", drop_cnt[0]);
        end
    endtask

    task automatic test_multicast();
        int base[4];
        int w;
        int stall_seen;
        stall_seen = 0;
        for (int i = 0; i < 4; i++) base[i] = rx_cnt[1][i];
        out_stop[1][2] = 1'b1;
        fork
            send_frame(1, 32'h10, 3, w);
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (in_stop[1]) stall_seen++;
                    @(posedge clk);
                end
                #1;
                out_stop[1][2] = 1'b0;
            end
        join
        drain();
        checks += 4;
        if (stall_seen == 0) begin
            failures++;
            $display("FAIL mc_in_stop_during_stall got=0 cycles required=>0");
        end
        if (rx_cnt[1][1] - base[1] !== 3 || rx_cnt[1][2] - base[2] !== 3) begin
            failures++;
            $display("FAIL mc_counts got=%0d,%0d required=3,3", rx_cnt[1][1] - base[1], rx_cnt[1][2] - base[2]);
        end
        if (rx_cnt[1][0] - base[0] + rx_cnt[1][3] - base[3] !== 0) begin
            failures++;
            $display("FAIL mc_other_outputs got=nonzero required=0");
        end
        if (pending() !== 0) begin
            failures++;
            $display("FAIL mc_pending got=%0d required=0", pending());
        end
    endtask

    task automatic test_drop();
        int base;
        int w;
        int stalls;
        stalls = 0;
        base = rx_cnt[1][0] + rx_cnt[1][1] + rx_cnt[1][2] + rx_cnt[1][3];
        for (int f = 0; f < 4; f++) begin
            send_frame(1, 32'hFF, $urandom_range(1, 3), w);
            stalls += w;
        end
        drain();
        checks += 3;
        if (drop_cnt[1] !== 16'd4) begin
            failures++;
            $display("FAIL drop_count got=%0d required=4", drop_cnt[1]);
        end
        if (stalls !== 0) begin
            failures++;
            $display("FAIL drop_stalled got=%0d required=0", stalls);
        end
        if (rx_cnt[1][0] + rx_cnt[1][1] + rx_cnt[1][2] + rx_cnt[1][3] - base !== 0) begin
            failures++;
            $display("FAIL drop_outputs got=nonzero required=0");
        end
    endtask

    task automatic test_default();
        int base[4];
        int w;
        for (int i = 0; i < 4; i++) base[i] = rx_cnt[2][i];
        send_frame(2, 32'hFF, 2, w);
        drain();
        checks += 3;
        if (rx_cnt[2][3] - base[3] !== 2) begin
            failures++;
            $display("FAIL default_out3 got=%0d required=2", rx_cnt[2][3] - base[3]);
        end
        if (rx_cnt[2][0] + rx_cnt[2][1] + rx_cnt[2][2] - base[0] - base[1] - base[2] !== 0) begin
            failures++;
            $display("FAIL default_other_outputs got=nonzero required=0");
        end
        if (drop_cnt[2] !== 16'd0) begin
            failures++;
            $display("FAIL default_drop got=%0d required=0", drop_cnt[2]);
        end
    endtask

    task automatic test_midframe_reset();
        int w;
        int b1;
        int b2;
        send_flit(0, 8'h00, {$urandom, $urandom, $urandom, 32'h2}, w);
        send_flit(0, 8'h00, {$urandom, $urandom, $urandom, $urandom}, w);
        repeat (6) @(posedge clk);
        #1;
        srst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        srst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (out_ready[0] !== 4'b0 || out_ready[1] !== 4'b0 || out_ready[2] !== 4'b0) begin
            failures++;
            $display("FAIL midreset_idle got=%b/%b/%b required=0", out_ready[0], out_ready[1], out_ready[2]);
        end
        if (drop_cnt[1] !== 16'd0) begin
            failures++;
            $display("FAIL midreset_drop got=%0d required=0", drop_cnt[1]);
        end
        @(posedge clk);
        #1;
        b1 = rx_cnt[0][1];
        b2 = rx_cnt[0][2];
        send_frame(0, 32'h1, 2, w);
        drain();
        checks += 2;
        if (rx_cnt[0][1] - b1 !== 2) begin
            failures++;
            $display("FAIL midreset_new_hdr got=%0d required=2", rx_cnt[0][1] - b1);
        end
        if (rx_cnt[0][2] - b2 !== 0) begin
            failures++;
            $display("FAIL midreset_old_route got=%0d required=0", rx_cnt[0][2] - b2);
        end
    endtask

    task automatic rand_frames(int k, int nframes);
        int w;
        int len;
        for (int f = 0; f < nframes; f++) begin
            len = $urandom_range(1, 4);
            send_frame(k, pick_type(), len, w);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        fork
            begin
                fork
                    rand_frames(0, 30);
                    rand_frames(1, 30);
                    rand_frames(2, 30);
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    for (int k = 0; k < 3; k++)
                        for (int i = 0; i < 4; i++) out_stop[k][i] = ($urandom_range(0, 3) == 0);
                end
            end
        join
        drain();
        checks++;
        if (pending() !== 0) begin
            failures++;
            $display("FAIL random_pending got=%0d required=0", pending());
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (drop_cnt[k] !== 16'(m_drop[k])) begin
                failures++;
                $display("FAIL random_drop inst=%0d got=%0d required=%0d", k, drop_cnt[k], m_drop[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int stalls;
        stalls = 0;
        in_eofc[1]  = 8'h01;
        in_data[1]  = {96'h0, 32'hFF};
        in_ready[1] = 1'b1;
        for (int n = 0; n < 65537; n++) begin
            @(negedge clk);
            if (in_stop[1]) stalls++;
            @(posedge clk);
        end
        #1;
        in_ready[1] = 1'b0;
        m_drop[1] = (m_drop[1] + 65537 > 65535) ? 65535 : m_drop[1] + 65537;
        @(negedge clk);
        checks += 2;
        if (drop_cnt[1] !== 16'(m_drop[1])) begin
            failures++;
            $display("FAIL sat_drop got=%h required=%h", drop_cnt[1], 16'(m_drop[1]));
        end
        if (stalls !== 0) begin
            failures++;
            $display("FAIL sat_stalled got=%0d required=0", stalls);
        end
    endtask

    initial begin
        cfg_match[0] = '{32'd0, 32'd1, 32'd2, 32'd3};
        cfg_mask[0]  = '{32'd3, 32'd3, 32'd3, 32'd3};
        cfg_mc[0]    = 1'b0;
        cfg_def[0]   = -1;
        cfg_match[1] = '{32'h20, 32'h10, 32'h10, 32'h30};
        cfg_mask[1]  = '{32'hFF, 32'hFF, 32'hFF, 32'hFF};
        cfg_mc[1]    = 1'b1;
        cfg_def[1]   = -1;
        cfg_match[2] = '{32'h20, 32'h10, 32'h10, 32'h30};
        cfg_mask[2]  = '{32'hFF, 32'hFF, 32'hFF, 32'hFF};
        cfg_mc[2]    = 1'b0;
        cfg_def[2]   = 3;

        test_reset();
        test_priority();
        test_multicast();
        test_drop();
        test_default();
        test_midframe_reset();
        test_random();
        test_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
